// File: rtl/a51_seq_pkg.sv
// rtl/a51_seq_pkg.sv - shared types and default lengths for the A5/1 sequencer
//
// Contents:
//   state_t          FSM state encoding, also driven out on the stage port
//   KEY_BITS         default serial key length
//   FRAME_BITS       default serial frame-number length
//   MIX_CYCLES       default number of discarded majority-clocked cycles
//   OUT_BITS         default keystream length per session
//   CNT_W            default phase counter width
//   at_last()        terminal-count helper used when sizing compare values

package a51_seq_pkg;

  localparam int KEY_BITS   = 64;
  localparam int FRAME_BITS = 22;
  localparam int MIX_CYCLES = 100;
  localparam int OUT_BITS   = 128;
  localparam int CNT_W      = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_KEY   = 3'd2,
    ST_FRAME = 3'd3,
    ST_MIX   = 3'd4,
    ST_OUT   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Counters compare against (length - 1), so the last cycle of a phase is
  // recognised while the counter still holds a value inside its range.
  function automatic int at_last(input int len);
    return len - 1;
  endfunction

endpackage

// File: rtl/a51_phase_counter.sv
// rtl/a51_phase_counter.sv - up-counter with sync clear, enable and terminal flag
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset, forces count to zero
//   clr       in   synchronous clear, wins over en
//   en        in   increment by one
//   limit     in   terminal value compared against the current count
//   cnt       out  current count
//   at_limit  out  high while cnt == limit

module a51_phase_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/a51_sequencer.sv
// rtl/a51_sequencer.sv - FSM sequencing the A5/1 keystream generator datapath
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   session request, honoured only in IDLE
//   abort      in   synchronous cancel, returns to IDLE from any state
//   key        in   session key, loaded LSB first
//   frame      in   frame number, loaded LSB first after the key
//   ks_ready   in   collector accepts the current keystream bit
//   lfsr_clr   out  one-cycle clear of all three LFSRs
//   load_en    out  clock all LFSRs unconditionally during KEY/FRAME
//   load_bit   out  bit XORed into every LFSR feedback while load_en=1
//   mix_en     out  majority clocking enable (MIX, and OUT on a transfer)
//   ks_valid   out  datapath output bit is valid
//   out_idx    out  keystream bits transferred so far
//   stage      out  encoded current state
//   busy       out  state != IDLE
//   done       out  one-cycle pulse after the final transfer
//   depleted   out  high from done until next accepted start, reset or abort

module a51_sequencer
  import a51_seq_pkg::*;
#(
  parameter int KEY_BITS   = a51_seq_pkg::KEY_BITS,
  parameter int FRAME_BITS = a51_seq_pkg::FRAME_BITS,
  parameter int MIX_CYCLES = a51_seq_pkg::MIX_CYCLES,
  parameter int OUT_BITS   = a51_seq_pkg::OUT_BITS,
  parameter int CNT_W      = a51_seq_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [KEY_BITS-1:0]   key,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  ks_ready,
  output logic                  lfsr_clr,
  output logic                  load_en,
  output logic                  load_bit,
  output logic                  mix_en,
  output logic                  ks_valid,
  output logic [CNT_W-1:0]      out_idx,
  output logic [2:0]            stage,
  output logic                  busy,
  output logic                  done,
  output logic                  depleted
);

  localparam int KEY_IW   = $clog2(KEY_BITS);
  localparam int FRAME_IW = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(at_last(KEY_BITS));
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(at_last(FRAME_BITS));
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(at_last(MIX_CYCLES));
  localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(at_last(OUT_BITS));

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_en;
  logic             cnt_clr;
  logic             cnt_last;
  logic             idx_last;
  logic             in_out;
  logic             xfer;

  // ---------------------------------------------------------------------------
  // Shared phase counter: runs through KEY, FRAME and MIX, cleared on every
  // phase exit so each phase starts counting from zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_limit = '1;
    case (state)
      ST_KEY:   cnt_limit = KEY_LAST;
      ST_FRAME: cnt_limit = FRAME_LAST;
      ST_MIX:   cnt_limit = MIX_LAST;
      default:  cnt_limit = '1;
    endcase
  end

  assign cnt_en  = (state == ST_KEY) || (state == ST_FRAME) || (state == ST_MIX);
  assign cnt_clr = !cnt_en || cnt_last || abort;

  a51_phase_counter #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .limit    (cnt_limit),
    .cnt      (cnt),
    .at_limit (cnt_last)
  );

  // ---------------------------------------------------------------------------
  // Keystream index: cleared only by CLR so it keeps OUT_BITS (or the count
  // at an abort) visible to the controller until the next session starts.
  // ---------------------------------------------------------------------------
  assign in_out = (state == ST_OUT);
  assign xfer   = in_out && ks_ready;

  a51_phase_counter #(
    .W (CNT_W)
  ) u_out_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == ST_CLR),
    .en       (xfer),
    .limit    (OUT_LAST),
    .cnt      (out_idx),
    .at_limit (idx_last)
  );

  // ---------------------------------------------------------------------------
  // FSM. Priority: reset, then abort, then the normal phase progression.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      depleted <= 1'b0;
    end else if (abort) begin
      // Abort also suppresses a start presented in the same IDLE cycle.
      state    <= ST_IDLE;
      depleted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_CLR;
            depleted <= 1'b0;
          end
        end
        ST_CLR:   state <= ST_KEY;
        ST_KEY:   if (cnt_last) state <= ST_FRAME;
        ST_FRAME: if (cnt_last) state <= ST_MIX;
        ST_MIX:   if (cnt_last) state <= ST_OUT;
        ST_OUT:   if (xfer && idx_last) state <= ST_DONE;
        ST_DONE: begin
          state    <= ST_IDLE;
          depleted <= 1'b1;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Everything follows registered state/counters except mix_en,
  // which must track ks_ready so the LFSRs advance only on an accepted bit.
  // ---------------------------------------------------------------------------
  assign lfsr_clr = (state == ST_CLR);
  assign load_en  = (state == ST_KEY) || (state == ST_FRAME);
  assign load_bit = ((state == ST_KEY)   && key[cnt[KEY_IW-1:0]]) ||
                    ((state == ST_FRAME) && frame[cnt[FRAME_IW-1:0]]);
  assign mix_en   = (state == ST_MIX) || xfer;
  assign ks_valid = in_out;
  assign stage    = state;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule
